lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32I load/store unit controller.
//
// Accepts one load or store from the core, turns it into a single word-aligned
// bus transaction with byte enables and lane-replicated store data, and returns
// sign/zero-extended load data with a one-cycle completion pulse.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_start, i_we           access request, 1=store / 0=load
//   i_funct3, i_addr        RV32I width code, byte address
//   i_wdata                 store data (rs2)
//   o_busy                  core stall
//   o_done, o_fault         completion pulse, access fault (valid with o_done)
//   o_rdata                 extended load data, held between loads
//   o_bus_req/we/addr/wdata/be, i_bus_ack, i_bus_rdata   memory bus
//
// Build option
//   LSU_MISALIGN_CHECK_EN   when defined, misaligned halfword/word accesses
//                           fault without touching the bus.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; access fields captured on acceptance
// REQ   | bus request held stable until i_bus_ack
// DONE  | one-cycle completion pulse (o_done, o_fault), back to IDLE
module lsu_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        fault_q;
    logic [31:0] rdata_q;

    logic        f3_ok;
    logic        misalign;
    logic        access_ok;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Legality of the incoming request, evaluated before capture.
    always_comb begin
        f3_ok = 1'b0;
        if (i_we) begin
            f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        end else begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
                default:                                f3_ok = 1'b0;
            endcase
        end
        misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        // funct3[1:0] encodes width for both loads and stores (01=half, 10=word).
        case (i_funct3[1:0])
            2'b01:   misalign = i_addr[0];
            2'b10:   misalign = |i_addr[1:0];
            default: misalign = 1'b0;
        endcase
`endif
        access_ok = f3_ok & ~misalign;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = access_ok ? REQ : DONE;
                end
            end
            REQ: begin
                if (i_bus_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else if (state_q == IDLE && i_start) begin
            we_q    <= i_we;
            f3_q    <= i_funct3;
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            fault_q <= ~access_ok;
        end
    end

    // Load lane extraction; halfwords look at addr[1] only so that a
    // misaligned halfword (when allowed) still reads a naturally aligned lane.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = i_bus_rdata[7:0];
            2'b01:   ld_byte = i_bus_rdata[15:8];
            2'b10:   ld_byte = i_bus_rdata[23:16];
            default: ld_byte = i_bus_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = i_bus_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= 32'h0;
        end else if (state_q == REQ && i_bus_ack && !we_q) begin
            rdata_q <= ld_data;
        end
    end

    // Store lanes; loads always fetch the full word.
    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                o_bus_be    = 4'b0001 << addr_q[1:0];
                o_bus_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                o_bus_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                o_bus_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                o_bus_be    = 4'b1111;
                o_bus_wdata = wdata_q;
            end
        endcase
        if (!we_q) begin
            o_bus_be = 4'b1111;
        end
    end

    assign o_bus_req  = (state_q == REQ);
    assign o_bus_we   = we_q;
    assign o_bus_addr = {addr_q[31:2], 2'b00};
    assign o_done     = (state_q == DONE);
    assign o_fault    = (state_q == DONE) & fault_q;
    assign o_busy     = (state_q == REQ) | ((state_q == IDLE) & i_start);
    assign o_rdata    = rdata_q;

endmodule
